// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs {instr_id, rd, rs1, rs2, imm} into a 32-bit word behind a small output FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       instr_id,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [5:0]
    I_INVALID = 6'd0,  I_LUI   = 6'd1,  I_AUIPC = 6'd2,  I_JAL   = 6'd3,  I_JALR  = 6'd4,
    I_BEQ     = 6'd5,  I_BNE   = 6'd6,  I_BLT   = 6'd7,  I_BGE   = 6'd8,  I_BLTU  = 6'd9,
    I_BGEU    = 6'd10, I_LB    = 6'd11, I_LH    = 6'd12, I_LW    = 6'd13, I_LBU   = 6'd14,
    I_LHU     = 6'd15, I_SB    = 6'd16, I_SH    = 6'd17, I_SW    = 6'd18, I_ADDI  = 6'd19,
    I_SLTI    = 6'd20, I_SLTIU = 6'd21, I_XORI  = 6'd22, I_ORI   = 6'd23, I_ANDI  = 6'd24,
    I_SLLI    = 6'd25, I_SRLI  = 6'd26, I_SRAI  = 6'd27, I_ADD   = 6'd28, I_SUB   = 6'd29,
    I_SLL     = 6'd30, I_SLT   = 6'd31, I_SLTU  = 6'd32, I_XOR   = 6'd33, I_SRL   = 6'd34,
    I_SRA     = 6'd35, I_OR    = 6'd36, I_AND   = 6'd37, I_ECALL = 6'd38, I_EBREAK = 6'd39,
    I_CSRRW   = 6'd40, I_CSRRS = 6'd41, I_CSRRC = 6'd42, I_CSRRWI = 6'd43, I_CSRRSI = 6'd44,
    I_CSRRCI  = 6'd45;

  localparam logic [6:0]
    OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BR = 7'h63,
    OP_LD  = 7'h03, OP_ST    = 7'h23, OP_IMM = 7'h13, OP_OP  = 7'h33, OP_SYS = 7'h73;

  localparam logic [3:0]
    F_BAD = 4'd0, F_R = 4'd1, F_I = 4'd2, F_SH = 4'd3, F_S = 4'd4, F_B = 4'd5,
    F_U   = 4'd6, F_J = 4'd7, F_CSR = 4'd8, F_SYS = 4'd9;

  logic [3:0]  fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] word;
  logic        rng_bad;
  logic [32:0] entry;

  // alt selects func7=0100000 for sub/sra/srai, and marks ebreak vs ecall
  always_comb begin
    {fmt, opc, f3, alt} = {F_BAD, 7'h0, 3'd0, 1'b0};
    case (instr_id)
      I_LUI:    {fmt, opc, f3, alt} = {F_U,   OP_LUI,   3'd0, 1'b0};
      I_AUIPC:  {fmt, opc, f3, alt} = {F_U,   OP_AUIPC, 3'd0, 1'b0};
      I_JAL:    {fmt, opc, f3, alt} = {F_J,   OP_JAL,   3'd0, 1'b0};
      I_JALR:   {fmt, opc, f3, alt} = {F_I,   OP_JALR,  3'd0, 1'b0};
      I_BEQ:    {fmt, opc, f3, alt} = {F_B,   OP_BR,    3'd0, 1'b0};
      I_BNE:    {fmt, opc, f3, alt} = {F_B,   OP_BR,    3'd1, 1'b0};
      I_BLT:    {fmt, opc, f3, alt} = {F_B,   OP_BR,    3'd4, 1'b0};
      I_BGE:    {fmt, opc, f3, alt} = {F_B,   OP_BR,    3'd5, 1'b0};
      I_BLTU:   {fmt, opc, f3, alt} = {F_B,   OP_BR,    3'd6, 1'b0};
      I_BGEU:   {fmt, opc, f3, alt} = {F_B,   OP_BR,    3'd7, 1'b0};
      I_LB:     {fmt, opc, f3, alt} = {F_I,   OP_LD,    3'd0, 1'b0};
      I_LH:     {fmt, opc, f3, alt} = {F_I,   OP_LD,    3'd1, 1'b0};
      I_LW:     {fmt, opc, f3, alt} = {F_I,   OP_LD,    3'd2, 1'b0};
      I_LBU:    {fmt, opc, f3, alt} = {F_I,   OP_LD,    3'd4, 1'b0};
      I_LHU:    {fmt, opc, f3, alt} = {F_I,   OP_LD,    3'd5, 1'b0};
      I_SB:     {fmt, opc, f3, alt} = {F_S,   OP_ST,    3'd0, 1'b0};
      I_SH:     {fmt, opc, f3, alt} = {F_S,   OP_ST,    3'd1, 1'b0};
      I_SW:     {fmt, opc, f3, alt} = {F_S,   OP_ST,    3'd2, 1'b0};
      I_ADDI:   {fmt, opc, f3, alt} = {F_I,   OP_IMM,   3'd0, 1'b0};
      I_SLTI:   {fmt, opc, f3, alt} = {F_I,   OP_IMM,   3'd2, 1'b0};
      I_SLTIU:  {fmt, opc, f3, alt} = {F_I,   OP_IMM,   3'd3, 1'b0};
      I_XORI:   {fmt, opc, f3, alt} = {F_I,   OP_IMM,   3'd4, 1'b0};
      I_ORI:    {fmt, opc, f3, alt} = {F_I,   OP_IMM,   3'd6, 1'b0};
      I_ANDI:   {fmt, opc, f3, alt} = {F_I,   OP_IMM,   3'd7, 1'b0};
      I_SLLI:   {fmt, opc, f3, alt} = {F_SH,  OP_IMM,   3'd1, 1'b0};
      I_SRLI:   {fmt, opc, f3, alt} = {F_SH,  OP_IMM,   3'd5, 1'b0};
      I_SRAI:   {fmt, opc, f3, alt} = {F_SH,  OP_IMM,   3'd5, 1'b1};
      I_ADD:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd0, 1'b0};
      I_SUB:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd0, 1'b1};
      I_SLL:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd1, 1'b0};
      I_SLT:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd2, 1'b0};
      I_SLTU:   {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd3, 1'b0};
      I_XOR:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd4, 1'b0};
      I_SRL:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd5, 1'b0};
      I_SRA:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd5, 1'b1};
      I_OR:     {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd6, 1'b0};
      I_AND:    {fmt, opc, f3, alt} = {F_R,   OP_OP,    3'd7, 1'b0};
      I_ECALL:  {fmt, opc, f3, alt} = {F_SYS, OP_SYS,   3'd0, 1'b0};
      I_EBREAK: {fmt, opc, f3, alt} = {F_SYS, OP_SYS,   3'd0, 1'b1};
      I_CSRRW:  {fmt, opc, f3, alt} = {F_CSR, OP_SYS,   3'd1, 1'b0};
      I_CSRRS:  {fmt, opc, f3, alt} = {F_CSR, OP_SYS,   3'd2, 1'b0};
      I_CSRRC:  {fmt, opc, f3, alt} = {F_CSR, OP_SYS,   3'd3, 1'b0};
      I_CSRRWI: {fmt, opc, f3, alt} = {F_CSR, OP_SYS,   3'd5, 1'b0};
      I_CSRRSI: {fmt, opc, f3, alt} = {F_CSR, OP_SYS,   3'd6, 1'b0};
      I_CSRRCI: {fmt, opc, f3, alt} = {F_CSR, OP_SYS,   3'd7, 1'b0};
      default:  {fmt, opc, f3, alt} = {F_BAD, 7'h0,     3'd0, 1'b0};
    endcase
  end

  always_comb begin
    word = 32'h0;
    case (fmt)
      F_R:        word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, opc};
      F_I, F_CSR: word = {imm[11:0], rs1, f3, rd, opc};
      F_SH:       word = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, opc};
      F_S:        word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      F_B:        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      F_U:        word = {imm[31:12], rd, opc};
      F_J:        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      F_SYS:      word = {11'b0, alt, 13'b0, opc};
      default:    word = 32'h0;
    endcase
  end

  always_comb begin
    rng_bad = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    case (fmt)
      F_I, F_S: rng_bad = imm[31:11] != {21{imm[31]}};
      F_B:      rng_bad = (imm[31:12] != {20{imm[31]}}) | imm[0];
      F_J:      rng_bad = (imm[31:20] != {12{imm[31]}}) | imm[0];
      F_U:      rng_bad = |imm[11:0];
      F_SH:     rng_bad = |imm[31:5];
      F_CSR:    rng_bad = |imm[31:12];
      default:  rng_bad = 1'b0;
    endcase
`else
    rng_bad = 1'b0;
`endif
    entry = ((fmt == F_BAD) | rng_bad) ? {1'b1, 32'h0} : {1'b0, word};
  end

  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [32:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic             push, pop;

  // in_ready depends on occupancy only, so a full FIFO never passes through on a pop
  assign in_ready  = cnt_q != (PW+1)'(FIFO_DEPTH);
  assign out_valid = cnt_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign out_err   = out_valid & mem_q[rd_ptr_q][32];
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + 1'b1;
      if (entry[32] && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written FIFO/reset sequences, and randomized
// traffic against a field-arithmetic reference model. Honors ENC_RANGE_CHECK_EN like the design.
module tb_instr_encoder;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [5:0]
    I_INVALID = 6'd0,  I_LUI  = 6'd1,  I_AUIPC = 6'd2,  I_JAL  = 6'd3,  I_JALR = 6'd4,
    I_BEQ = 6'd5, I_BNE = 6'd6, I_BLT = 6'd7, I_BGE = 6'd8, I_BLTU = 6'd9, I_BGEU = 6'd10,
    I_LB = 6'd11, I_LH = 6'd12, I_LW = 6'd13, I_LBU = 6'd14, I_LHU = 6'd15,
    I_SB = 6'd16, I_SH = 6'd17, I_SW = 6'd18, I_ADDI = 6'd19, I_SLTI = 6'd20, I_SLTIU = 6'd21,
    I_XORI = 6'd22, I_ORI = 6'd23, I_ANDI = 6'd24, I_SLLI = 6'd25, I_SRLI = 6'd26, I_SRAI = 6'd27,
    I_ADD = 6'd28, I_SUB = 6'd29, I_SLL = 6'd30, I_SLT = 6'd31, I_SLTU = 6'd32, I_XOR = 6'd33,
    I_SRL = 6'd34, I_SRA = 6'd35, I_OR = 6'd36, I_AND = 6'd37, I_ECALL = 6'd38, I_EBREAK = 6'd39,
    I_CSRRW = 6'd40, I_CSRRS = 6'd41, I_CSRRC = 6'd42, I_CSRRWI = 6'd43, I_CSRRSI = 6'd44,
    I_CSRRCI = 6'd45;

  localparam int K_NONE = 0, K_R = 1, K_I = 2, K_SH = 3, K_S = 4, K_B = 5, K_U = 6, K_J = 7,
                 K_CSR = 8, K_SYS = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [5:0]  instr_id = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [CW-1:0] enc_count, err_count;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_id(instr_id), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ISA table: format kind, opcode (or the whole fixed word for ecall/ebreak), funct3, func7 bit 30
  typedef struct { int kind; int op; int f3; int alt; } spec_t;
  spec_t tab [64];

  function automatic void def(input logic [5:0] id, input int k, input int op, input int f3, input int alt);
    tab[id] = '{k, op, f3, alt};
  endfunction

  function automatic logic [32:0] ref_enc(input logic [5:0] id, input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [31:0] im);
    spec_t       s = tab[id];
    logic [31:0] w = 32'd0;
    logic [31:0] rdv = 32'(a), r1 = 32'(b) << 15, r2 = 32'(c) << 20;
    logic [31:0] o = 32'(s.op), f = 32'(s.f3) << 12, hi = 32'(s.alt) << 30;
    int          si = $signed(im);
    logic        bad = 1'b0;
    case (s.kind)
      K_R:   w = hi | r2 | r1 | f | (rdv << 7) | o;
      K_I:   begin bad = si < -2048 || si > 2047; w = ((im & 32'hFFF) << 20) | r1 | f | (rdv << 7) | o; end
      K_SH:  begin bad = im > 32'd31; w = hi | ((im & 32'd31) << 20) | r1 | f | (rdv << 7) | o; end
      K_S:   begin
        bad = si < -2048 || si > 2047;
        w = (((im >> 5) & 32'd127) << 25) | r2 | r1 | f | ((im & 32'd31) << 7) | o;
      end
      K_B:   begin
        bad = si < -4096 || si > 4095 || im[0];
        w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25) | r2 | r1 | f |
            (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7) | o;
      end
      K_U:   begin bad = (im & 32'hFFF) != 0; w = (im & 32'hFFFFF000) | (rdv << 7) | o; end
      K_J:   begin
        bad = si < -(1 << 20) || si >= (1 << 20) || im[0];
        w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'd1023) << 21) | (((im >> 11) & 32'd1) << 20) |
            (((im >> 12) & 32'd255) << 12) | (rdv << 7) | o;
      end
      K_CSR: begin bad = im > 32'd4095; w = ((im & 32'hFFF) << 20) | r1 | f | (rdv << 7) | o; end
      K_SYS: w = o;
      default: return {1'b1, 32'h0};
    endcase
`ifndef ENC_RANGE_CHECK_EN
    bad = 1'b0;
`endif
    return bad ? {1'b1, 32'h0} : {1'b0, w};
  endfunction

  // Model state: expected FIFO contents and saturating counters
  logic [32:0] q [$];
  int enc_n = 0, err_n = 0;

  task automatic check_state(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
    chk({tag, ".out_instr"}, out_instr, q.size() != 0 ? q[0][31:0] : 32'h0);
    chk({tag, ".out_err"},   32'(out_err),   q.size() != 0 ? 32'(q[0][32]) : 32'h0);
    chk({tag, ".enc_count"}, 32'(enc_count), 32'(enc_n));
    chk({tag, ".err_count"}, 32'(err_count), 32'(err_n));
  endtask

  // One clock of traffic: drive, check state at negedge, advance model across the posedge
  task automatic step(input string tag, input logic v, input logic [5:0] id, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c, input logic [31:0] im, input logic ordy);
    logic acc, pp;
    logic [32:0] e;
    in_valid = v; instr_id = id; rd = a; rs1 = b; rs2 = c; imm = im; out_ready = ordy;
    @(negedge clk);
    check_state(tag);
    acc = v && q.size() < DEPTH;
    pp  = q.size() > 0 && ordy;
    @(posedge clk); #1;
    if (pp) void'(q.pop_front());
    if (acc) begin
      e = ref_enc(id, a, b, c, im);
      q.push_back(e);
      if (enc_n < CMAX) enc_n++;
      if (e[32] && err_n < CMAX) err_n++;
    end
  endtask

  typedef struct {
    string name; logic [5:0] id; logic [4:0] a, b, c; logic [31:0] im; logic [31:0] ew; logic ee;
  } vec_t;
  vec_t vecs [$];

  task automatic add(input string n, input logic [5:0] id, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] c, input logic [31:0] im, input logic [31:0] ew, input logic ee);
    vec_t v;
    v = '{n, id, a, b, c, im, ew, ee};
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] bnd [10];
    logic [31:0] im;
    logic [5:0]  id;
    int          exp_err;

    for (int i = 0; i < 64; i++) def(6'(i), K_NONE, 0, 0, 0);
    def(I_LUI, K_U, 'h37, 0, 0);  def(I_AUIPC, K_U, 'h17, 0, 0);
    def(I_JAL, K_J, 'h6F, 0, 0);  def(I_JALR, K_I, 'h67, 0, 0);
    def(I_BEQ, K_B, 'h63, 0, 0);  def(I_BNE, K_B, 'h63, 1, 0);  def(I_BLT, K_B, 'h63, 4, 0);
    def(I_BGE, K_B, 'h63, 5, 0);  def(I_BLTU, K_B, 'h63, 6, 0); def(I_BGEU, K_B, 'h63, 7, 0);
    def(I_LB, K_I, 'h03, 0, 0);   def(I_LH, K_I, 'h03, 1, 0);   def(I_LW, K_I, 'h03, 2, 0);
    def(I_LBU, K_I, 'h03, 4, 0);  def(I_LHU, K_I, 'h03, 5, 0);
    def(I_SB, K_S, 'h23, 0, 0);   def(I_SH, K_S, 'h23, 1, 0);   def(I_SW, K_S, 'h23, 2, 0);
    def(I_ADDI, K_I, 'h13, 0, 0); def(I_SLTI, K_I, 'h13, 2, 0); def(I_SLTIU, K_I, 'h13, 3, 0);
    def(I_XORI, K_I, 'h13, 4, 0); def(I_ORI, K_I, 'h13, 6, 0);  def(I_ANDI, K_I, 'h13, 7, 0);
    def(I_SLLI, K_SH, 'h13, 1, 0); def(I_SRLI, K_SH, 'h13, 5, 0); def(I_SRAI, K_SH, 'h13, 5, 1);
    def(I_ADD, K_R, 'h33, 0, 0);  def(I_SUB, K_R, 'h33, 0, 1);  def(I_SLL, K_R, 'h33, 1, 0);
    def(I_SLT, K_R, 'h33, 2, 0);  def(I_SLTU, K_R, 'h33, 3, 0); def(I_XOR, K_R, 'h33, 4, 0);
    def(I_SRL, K_R, 'h33, 5, 0);  def(I_SRA, K_R, 'h33, 5, 1);  def(I_OR, K_R, 'h33, 6, 0);
    def(I_AND, K_R, 'h33, 7, 0);
    def(I_ECALL, K_SYS, 'h00000073, 0, 0); def(I_EBREAK, K_SYS, 'h00100073, 0, 0);
    def(I_CSRRW, K_CSR, 'h73, 1, 0);  def(I_CSRRS, K_CSR, 'h73, 2, 0);  def(I_CSRRC, K_CSR, 'h73, 3, 0);
    def(I_CSRRWI, K_CSR, 'h73, 5, 0); def(I_CSRRSI, K_CSR, 'h73, 6, 0); def(I_CSRRCI, K_CSR, 'h73, 7, 0);

    add("addi",     I_ADDI,   1, 0, 0, 32'd5,        32'h00500093, 1'b0);
    add("sub",      I_SUB,    3, 1, 2, 32'd0,        32'h402081B3, 1'b0);
    add("ebreak",   I_EBREAK, 7, 3, 9, 32'h1234,     32'h00100073, 1'b0);
    add("beq",      I_BEQ,    0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    add("jal",      I_JAL,    1, 0, 0, 32'h800,      32'h001000EF, 1'b0);
    add("lui",      I_LUI,    5, 0, 0, 32'h12345000, 32'h123452B7, 1'b0);
    add("sw",       I_SW,     0, 2, 3, 32'd8,        32'h00312423, 1'b0);
    add("srai",     I_SRAI,   1, 1, 0, 32'd3,        32'h4030D093, 1'b0);
    add("csrrw",    I_CSRRW,  1, 2, 0, 32'h300,      32'h300110F3, 1'b0);
    add("csrrwi",   I_CSRRWI, 1, 5, 0, 32'h305,      32'h3052D0F3, 1'b0);
    add("ecall",    I_ECALL,  9, 9, 9, 32'hFFFFFFFF, 32'h00000073, 1'b0);
    add("lw_neg",   I_LW,     2, 1, 0, 32'hFFFFFFFC, 32'hFFC0A103, 1'b0);
    add("invalid",  I_INVALID, 1, 1, 1, 32'd1,       32'h0,        1'b1);
    add("unknown",  6'h3F,    1, 1, 1, 32'd1,        32'h0,        1'b1);
`ifdef ENC_RANGE_CHECK_EN
    add("addi_800", I_ADDI,   1, 0, 0, 32'h800,      32'h0,        1'b1);
    add("slli_big", I_SLLI,   1, 1, 0, 32'h25,       32'h0,        1'b1);
    exp_err = 4;
`else
    add("addi_800", I_ADDI,   1, 0, 0, 32'h800,      32'h80000093, 1'b0);
    add("slli_big", I_SLLI,   1, 1, 0, 32'h25,       32'h00509093, 1'b0);
    exp_err = 2;
`endif

    // Reset state, both during and just after reset
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_instr", out_instr, 32'h0);
    chk("rst.enc_count", 32'(enc_count), 32'h0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'h1);
    chk("rst.out_err", 32'(out_err), 32'h0);
    chk("rst.err_count", 32'(err_count), 32'h0);

    // Directed vectors: each lands at the head one edge after acceptance
    foreach (vecs[i]) begin
      step({"vec.", vecs[i].name}, 1'b1, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].im, 1'b1);
      chk({"vec.", vecs[i].name, ".valid"}, 32'(out_valid), 32'h1);
      chk({"vec.", vecs[i].name, ".word"}, out_instr, vecs[i].ew);
      chk({"vec.", vecs[i].name, ".err"}, 32'(out_err), 32'(vecs[i].ee));
      if (i == 2) chk("vec.enc_after3", 32'(enc_count), 32'd3);
    end
    chk("vec.enc_saturated", 32'(enc_count), 32'(CMAX));
    chk("vec.err_total", 32'(err_count), 32'(exp_err));
    step("drain", 1'b0, '0, '0, '0, '0, '0, 1'b1);

    // Back-pressure: three requests against a stalled consumer, then drain in order
    step("bp1", 1'b1, I_ADDI, 1, 0, 0, 32'd1, 1'b0);
    step("bp2", 1'b1, I_ADDI, 1, 0, 0, 32'd2, 1'b0);
    step("bp3", 1'b1, I_ADDI, 1, 0, 0, 32'd3, 1'b0);
    chk("bp.in_ready_full", 32'(in_ready), 32'h0);
    chk("bp.head1", out_instr, 32'h00100093);
    step("bp4", 1'b1, I_ADDI, 1, 0, 0, 32'd3, 1'b1);
    chk("bp.head2", out_instr, 32'h00200093);
    step("bp5", 1'b1, I_ADDI, 1, 0, 0, 32'd3, 1'b1);
    chk("bp.head3", out_instr, 32'h00300093);
    step("bp6", 1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("bp.empty", 32'(out_valid), 32'h0);

    // Asynchronous reset with an entry queued
    step("ar1", 1'b1, I_ADDI, 1, 0, 0, 32'd7, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'h0);
    chk("arst.enc_count", 32'(enc_count), 32'h0);
    chk("arst.err_count", 32'(err_count), 32'h0);
    q.delete(); enc_n = 0; err_n = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step("post_rst", 1'b1, 6'h3F, 0, 0, 0, 32'd0, 1'b0);
    chk("post_rst.unknown_err", 32'(out_err), 32'h1);
    chk("post_rst.err_count", 32'(err_count), 32'h1);

    // Random traffic against the model
    bnd = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFF, 32'h1000,
            32'hFFFFF000, 32'h000FFFFF, 32'hFFF00000, 32'h1F};
    for (int n = 0; n < 600; n++) begin
      id = 6'($urandom_range(0, 49));
      case ($urandom_range(0, 3))
        0: im = 32'($urandom_range(0, 40));
        1: im = -32'($urandom_range(0, 40));
        2: im = $urandom;
        default: im = bnd[$urandom_range(0, 9)];
      endcase
      step("rnd", 1'($urandom_range(0, 3) != 0), id, 5'($urandom), 5'($urandom), 5'($urandom), im,
           1'($urandom_range(0, 2) != 0));
    end
    for (int n = 0; n < 3; n++) step("rnd_drain", 1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("rnd.empty", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
